io_bank_responder: RTL and testbench
====================================

# io_bank_responder

Memory-mapped I/O responder for bank 2 of the MIPS32 SoC data bus, occupying virtual words 0xFFFF0000–0xFFFF000B (physical offsets 0x0–0xB). The address decoder selects the bank and supplies a 13-bit physical offset and a bank enable; this block completes the transaction. It answers with registered read data one cycle later, or updates its registers on a write. It exposes three words:

- a keypad status word with sticky press-event flags (cleared on read),
- a free-running millisecond counter,
- a control word.

## Interface
Parameters:
- CLK_FREQ_HZ, 50000000, core clock frequency. The millisecond prescaler divides by CLK_FREQ_HZ/1000, which must be ≥ 2.
- KEY_W, 8, number of keypad/button inputs, 1..16.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  bank-2 enable, driven by the decoder's memEn[2].
- memWrite  in  1  write strobe.
- memRead  in  1  read strobe.
- physAddr  in  13  physical offset. Only bits [3:2] select the word; bits [1:0] and [12:4] are ignored.
- wdata  in  32  write data.
- keyIn  in  KEY_W  raw asynchronous button levels, active-high.
- rdata  out  32  registered read data.
- tickMs  out  1  one-cycle pulse each time the millisecond counter increments.

## Operation
Access rules:
- A transaction is accepted only when en=1. With en=0, memWrite and memRead are ignored.
- If memWrite=1 and memRead=1 in the same cycle, the write is performed and the read is ignored.

Word map (index = physAddr[3:2]):
- Word 0, KEYS (read-only; writes ignored). Read value = {16'h0 with pending[KEY_W-1:0] in bits [31:16], keySync[KEY_W-1:0] in bits [15:0]}; unused high bits read as 0.
- Word 1, MSCNT (read/write). 32-bit millisecond counter; a write loads wdata.
- Word 2, CTRL (read/write).
  - Bit 0, tmrEn: reset value 1.
  - Bit 1, clrKeys: write-only, self-clearing. Writing 1 clears all pending bits.
  - Read value = {31'h0, tmrEn}.
- Word 3: reads return 0; writes are ignored.

Key path:
- keyIn passes through a 2-flop synchronizer to produce keySync.
- Each 0→1 edge of a keySync bit sets the corresponding pending bit.
- Reading word 0 clears every pending bit whose value was returned by that read.
- If a new edge and a clear (read-clear or clrKeys) land in the same cycle, the new edge wins and the bit stays set.

Timer path:
- While tmrEn=1, prescaler counts 0..CLK_FREQ_HZ/1000−1. At the terminal count it returns to 0, tickMs pulses, and MSCNT increments.
- MSCNT wraps 0xFFFFFFFF→0.
- While tmrEn=0, the prescaler and MSCNT hold and tickMs stays 0.
- Writing tmrEn=0 does not reset the prescaler. Re-enabling resumes from the held prescaler value.
- A write to MSCNT in the same cycle as a tick loads wdata; the increment is lost. The prescaler still wraps.

## Timing
Reset values:
- rdata=0, tickMs=0, MSCNT=0, prescaler=0, pending=0, sync flops=0, tmrEn=1.

Read path:
- Read latency is 1 cycle. rdata is updated on the edge that samples the read strobe and is valid in the following cycle.
- rdata holds its last value when no read is accepted.
- A read returns register values from before that edge: a word-0 read returns pending bits before clearing; a MSCNT read returns the value before that edge's increment.

Write path:
- Write effect is visible to a read issued on the next cycle.

Keypad path:
- Latency from a keyIn rising edge to a pending bit set: 3 clock edges (2 sync stages plus the edge-detect register).

Reset behaviour:
- Reset asserted mid-operation clears all state immediately, with no clock required.
- The first access after deassertion is serviced normally.

## Test plan
Unless noted, CLK_FREQ_HZ=4000 (4 cycles/ms) and KEY_W=8.

- Reset and tick rate: release reset and idle 20 cycles → tickMs pulses at cycles 4, 8, …; a read of word 1 returns 5; rdata=0 before the first read.
- Key event and read-clear: pulse keyIn[3] high for 2 cycles, wait 5 cycles, read word 0 → 0x0008_0000. A second read returns 0x0000_0000.
- Key edge vs. clear race: arrange for a keyIn[0] sync edge to coincide with a word-0 read (pending[0] already 1) → the read returns bit 16 set, and the next read still returns bit 16 set.
- Timer enable and MSCNT wrap: write CTRL=0 and idle 40 cycles → MSCNT unchanged and tickMs=0. Write MSCNT=0xFFFFFFFF, then CTRL=1, wait 4 cycles → MSCNT reads 0.
- Access gating and collisions:
  - A write to word 1 with en=0 → no effect.
  - memWrite and memRead together to word 1 with wdata=0x1234 → rdata unchanged; the next read returns 0x1234 (or 0x1235 if a tick intervened).
  - Word-3 read → 0.
- Asynchronous reset mid-count: assert rst between edges while MSCNT=7 and pending≠0 → MSCNT, pending and rdata are 0 with no clock edge required, and tmrEn reads 1 afterwards.

Source files
------------

// File: rtl/io_bank_responder.sv
// Bank-2 MMIO responder: keypad status with sticky press flags,
// free-running millisecond counter and timer control word.
module io_bank_responder #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int KEY_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             memWrite,
  input  logic             memRead,
  input  logic [12:0]      physAddr,
  input  logic [31:0]      wdata,
  input  logic [KEY_W-1:0] keyIn,
  output logic [31:0]      rdata,
  output logic             tickMs
);

  localparam int DIV = CLK_FREQ_HZ / 1000;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  logic [1:0]       word;
  logic             wrAcc;
  logic             rdAcc;
  logic             selKeys;
  logic             selMs;
  logic             selCtrl;
  logic             selNone;

  logic [KEY_W-1:0] keySync1;
  logic [KEY_W-1:0] keySync;
  logic [KEY_W-1:0] keyPrev;
  logic [KEY_W-1:0] pending;
  logic [KEY_W-1:0] keyEdge;
  logic [KEY_W-1:0] clrMask;

  logic [PW-1:0]    presc;
  logic [31:0]      msCnt;
  logic             tmrEn;
  logic             wrap;

  logic [31:0]      keyWord;
  logic [31:0]      readMux;
  logic             unusedAddr;

  assign unusedAddr = ^{physAddr[12:4], physAddr[1:0]};

  assign word    = physAddr[3:2];
  assign wrAcc   = en & memWrite;
  // a simultaneous write wins, so the read (and its clear) is dropped
  assign rdAcc   = en & memRead & ~memWrite;
  assign selKeys = (word == 2'd0);
  assign selMs   = (word == 2'd1);
  assign selCtrl = (word == 2'd2);
  assign selNone = (word == 2'd3);

  assign keyEdge = keySync & ~keyPrev;
  assign wrap    = tmrEn && (presc == TERM);
  assign keyWord = (32'(pending) << 16) | 32'(keySync);

  always_comb begin
    clrMask = '0;
    if (rdAcc && selKeys)
      clrMask = pending;
    if (wrAcc && selCtrl && wdata[1])
      clrMask = '1;
  end

  always_comb begin
    readMux = '0;
    unique case (1'b1)
      selKeys: readMux = keyWord;
      selMs:   readMux = msCnt;
      selCtrl: readMux = {31'h0, tmrEn};
      selNone: readMux = '0;
      default: readMux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keySync1 <= '0;
      keySync  <= '0;
      keyPrev  <= '0;
      pending  <= '0;
    end else begin
      keySync1 <= keyIn;
      keySync  <= keySync1;
      keyPrev  <= keySync;
      // new edges are ORed after the clear so they survive a race
      pending  <= (pending & ~clrMask) | keyEdge;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      tickMs <= 1'b0;
      msCnt  <= '0;
      tmrEn  <= 1'b1;
    end else begin
      if (tmrEn)
        presc <= wrap ? '0 : presc + 1'b1;
      tickMs <= wrap;
      if (wrAcc && selMs)
        msCnt <= wdata;
      else if (wrap)
        msCnt <= msCnt + 32'd1;
      if (wrAcc && selCtrl)
        tmrEn <= wdata[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata <= '0;
    else if (rdAcc)
      rdata <= readMux;
  end

endmodule

// File: tb/tb_io_bank_responder.sv
// Randomized self-checking bench for io_bank_responder
// against a cycle-level behavioural model of the register map.
module tb_io_bank_responder;

  localparam int DIV = 4;
  localparam int KW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          memWrite = 1'b0;
  logic          memRead = 1'b0;
  logic [12:0]   physAddr = '0;
  logic [31:0]   wdata = '0;
  logic [KW-1:0] keyIn = '0;
  logic [31:0]   rdata;
  logic          tickMs;

  int checks = 0;
  int failures = 0;

  int            mPresc;
  logic [31:0]   mMs;
  logic [KW-1:0] mPend;
  logic [KW-1:0] s0, s1, s2;
  logic          mEn;
  logic [31:0]   mRd;
  logic          mTick;

  io_bank_responder #(
    .CLK_FREQ_HZ(4000),
    .KEY_W(KW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .memWrite(memWrite),
    .memRead(memRead),
    .physAddr(physAddr),
    .wdata(wdata),
    .keyIn(keyIn),
    .rdata(rdata),
    .tickMs(tickMs)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic mdlReset();
    mPresc = 0;
    mMs    = '0;
    mPend  = '0;
    s0     = '0;
    s1     = '0;
    s2     = '0;
    mEn    = 1'b1;
    mRd    = '0;
    mTick  = 1'b0;
  endtask

  // one bus cycle: drive inputs, advance model, clock, settle
  task automatic cyc(input bit e, input bit w, input bit r,
                     input logic [12:0] a, input logic [31:0] d);
    bit            wr, rd, wrapNow;
    logic [1:0]    wd;
    logic [KW-1:0] clr, edg;
    en = e; memWrite = w; memRead = r; physAddr = a; wdata = d;
    wr = e && w;
    rd = e && r && !w;
    wd = a[3:2];
    edg = s1 & ~s2;
    if (rd) begin
      case (wd)
        2'd0: mRd = {8'h0, mPend, 8'h0, s1};
        2'd1: mRd = mMs;
        2'd2: mRd = {31'h0, mEn};
        default: mRd = '0;
      endcase
    end
    clr = '0;
    if (rd && wd == 2'd0) clr = mPend;
    if (wr && wd == 2'd2 && d[1]) clr = '1;
    mPend = (mPend & ~clr) | edg;
    wrapNow = mEn && (mPresc == DIV - 1);
    if (mEn) mPresc = (mPresc + 1) % DIV;
    mTick = wrapNow;
    if (wr && wd == 2'd1) mMs = d;
    else if (wrapNow) mMs = mMs + 32'd1;
    if (wr && wd == 2'd2) mEn = d[0];
    s2 = s1;
    s1 = s0;
    s0 = keyIn;
    @(posedge clk);
    #1;
    en = 1'b0; memWrite = 1'b0; memRead = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", rdata);
    end
    checks++;
    if (tickMs !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0", tickMs);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    mdlReset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, '0, '0);
      checks++;
      if (tickMs !== ((i % 4) == 3)) begin
        failures++;
        $display("FAIL tick_rate cyc=%0d got=%b exp=%b", i + 1, tickMs, (i % 4) == 3);
      end
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL rdata_before_read got=%h exp=0", rdata);
    end
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if (rdata !== 32'd5 || rdata !== mRd) begin
      failures++;
      $display("FAIL mscnt_after_20 got=%h exp=%h", rdata, 32'd5);
    end
  endtask

  task automatic test_key_event();
    keyIn = 8'h08;
    idle(2);
    keyIn = 8'h00;
    idle(5);
    cyc(1, 0, 1, 13'h0, '0);
    checks++;
    if (rdata !== 32'h0008_0000 || rdata !== mRd) begin
      failures++;
      $display("FAIL key_event got=%h exp=%h", rdata, 32'h0008_0000);
    end
    cyc(1, 0, 1, 13'h0, '0);
    checks++;
    if (rdata !== 32'h0 || rdata !== mRd) begin
      failures++;
      $display("FAIL key_read_clear got=%h exp=0", rdata);
    end
  endtask

  task automatic test_race();
    keyIn = 8'h01;
    idle(4);
    keyIn = 8'h00;
    idle(4);
    keyIn = 8'h01;
    idle(2);
    cyc(1, 0, 1, 13'h0, '0);
    checks++;
    if (rdata[16] !== 1'b1 || rdata !== mRd) begin
      failures++;
      $display("FAIL race_first got=%h exp=%h", rdata, mRd);
    end
    cyc(1, 0, 1, 13'h0, '0);
    checks++;
    if (rdata[16] !== 1'b1 || rdata !== mRd) begin
      failures++;
      $display("FAIL race_second got=%h exp=%h", rdata, mRd);
    end
    keyIn = 8'h00;
    idle(3);
    cyc(1, 0, 1, 13'h0, '0);
  endtask

  task automatic test_timer();
    logic [31:0] held;
    bit          sawTick;
    cyc(1, 1, 0, 13'h8, 32'h0);
    held = mMs;
    sawTick = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 0, '0, '0);
      if (tickMs !== 1'b0) sawTick = 1'b1;
    end
    checks++;
    if (sawTick) begin
      failures++;
      $display("FAIL tick_while_disabled got=1 exp=0");
    end
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if (rdata !== held || rdata !== mRd) begin
      failures++;
      $display("FAIL mscnt_held got=%h exp=%h", rdata, held);
    end
    cyc(1, 1, 0, 13'h4, 32'hFFFF_FFFF);
    cyc(1, 1, 0, 13'h8, 32'h1);
    idle(4);
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if (rdata !== 32'h0 || rdata !== mRd) begin
      failures++;
      $display("FAIL mscnt_wrap got=%h exp=0", rdata);
    end
  endtask

  task automatic test_gating();
    logic [31:0] prev;
    cyc(0, 1, 0, 13'h4, 32'hDEAD_BEEF);
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if (rdata === 32'hDEAD_BEEF || rdata !== mRd) begin
      failures++;
      $display("FAIL write_en0 got=%h exp=%h", rdata, mRd);
    end
    prev = mRd;
    cyc(1, 1, 1, 13'h4, 32'h1234);
    checks++;
    if (rdata !== prev) begin
      failures++;
      $display("FAIL collision_rdata got=%h exp=%h", rdata, prev);
    end
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if ((rdata !== 32'h1234 && rdata !== 32'h1235) || rdata !== mRd) begin
      failures++;
      $display("FAIL collision_write got=%h exp=%h", rdata, mRd);
    end
    cyc(1, 1, 0, 13'h1FFC, 32'hFFFF_FFFF);
    cyc(1, 0, 1, 13'h1FFF, '0);
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL word3_read got=%h exp=0", rdata);
    end
    cyc(1, 1, 0, 13'h0, 32'hFFFF_FFFF);
    cyc(1, 0, 1, 13'h0, '0);
    checks++;
    if (rdata !== mRd) begin
      failures++;
      $display("FAIL word0_write_ignored got=%h exp=%h", rdata, mRd);
    end
  endtask

  task automatic test_random();
    int          errR, errT;
    logic [1:0]  w;
    logic [31:0] d;
    errR = 0;
    errT = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) keyIn = KW'($urandom);
      w = 2'($urandom_range(0, 3));
      d = $urandom;
      if (w == 2'd2) d[0] = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1,
          {9'($urandom), w, 2'($urandom)}, d);
      checks++;
      if (rdata !== mRd) begin
        failures++;
        errR++;
        if (errR < 5) $display("FAIL random_rdata cyc=%0d got=%h exp=%h", i, rdata, mRd);
      end
      checks++;
      if (tickMs !== mTick) begin
        failures++;
        errT++;
        if (errT < 5) $display("FAIL random_tick cyc=%0d got=%b exp=%b", i, tickMs, mTick);
      end
    end
    keyIn = '0;
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 0, 13'h8, 32'h0);
    cyc(1, 1, 0, 13'h4, 32'd7);
    keyIn = 8'h20;
    idle(3);
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if (rdata !== 32'd7 || rdata !== mRd) begin
      failures++;
      $display("FAIL pre_reset_mscnt got=%h exp=7", rdata);
    end
    keyIn = 8'h00;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h0 || tickMs !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b exp=0/0", rdata, tickMs);
    end
    mdlReset();
    #2;
    rst = 1'b0;
    cyc(1, 0, 1, 13'h8, '0);
    checks++;
    if (rdata !== 32'h1 || rdata !== mRd) begin
      failures++;
      $display("FAIL reset_tmren got=%h exp=1", rdata);
    end
    cyc(1, 0, 1, 13'h4, '0);
    checks++;
    if (rdata !== 32'h0 || rdata !== mRd) begin
      failures++;
      $display("FAIL reset_mscnt got=%h exp=0", rdata);
    end
    cyc(1, 0, 1, 13'h0, '0);
    checks++;
    if (rdata !== 32'h0 || rdata !== mRd) begin
      failures++;
      $display("FAIL reset_pending got=%h exp=0", rdata);
    end
  endtask

  initial begin
    mdlReset();
    test_reset();
    test_key_event();
    test_race();
    test_timer();
    test_gating();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
